serial_link_tx: RTL
===================

# serial_link_tx

Parametrised serial transmitter for the inter-board GPIO link between a transfer center and a scanner. Words written by local logic are buffered in a FIFO of configurable depth and width. Each word is shifted out bit-serially on a data/clock pair, framed by a ready-to-transmit strobe, and gated by the remote side's ready-for-transfer input. It replaces the fixed 4-bit, single-word, unbuffered transfer path. The bit rate is derived from the system clock, so no separate divided clock is needed.

## Interface
- DATA_WIDTH, 4: bits per word; ≥1.
- DEPTH, 4: FIFO entries; ≥2.
- CLK_DIV, 4: clk cycles per serial bit; even, ≥2.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.

- clk  in  1  system clock; all logic on rising edge. One clock domain only.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  push wr_data when not full.
- wr_data  in  DATA_WIDTH  word to transmit.
- remote_ready  in  1  remote ready-for-transfer; asynchronous, 2-flop synchronised internally.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  words currently buffered; excludes the word in flight.
- overflow  out  1  one-cycle pulse when wr_en is asserted while full.
- tx_ready  out  1  ready-to-transmit strobe to the remote side.
- ser_clk  out  1  serial clock; remote samples on rising edge.
- ser_data  out  1  serial data.
- busy  out  1  state != IDLE.
- word_done  out  1  one-cycle pulse after the last bit period of a word.

## Operation
- FIFO is a circular buffer with read/write pointers wrapping at DEPTH.
  - Push: wr_en && !full.
  - Pop: taken on the REQ→SHIFT transition.
  - Push and pop in the same cycle leave count unchanged.
  - A write while full is dropped even if a pop occurs that cycle; overflow pulses.
- ready_s is remote_ready after two flops.
- States:
  - IDLE: tx_ready=0. Go to REQ when count>0.
  - REQ: tx_ready=1. Stay until ready_s=1; then pop the FIFO head into the shift register, clear bit_cnt and div_cnt, and go to SHIFT.
  - SHIFT: tx_ready=1.
    - ser_data = current shift-register output bit.
    - ser_clk = (div_cnt ≥ CLK_DIV/2).
    - div_cnt increments every cycle. At div_cnt == CLK_DIV-1: div_cnt→0, shift by one, bit_cnt++.
    - When the last bit period ends (bit_cnt == DATA_WIDTH-1 and div_cnt == CLK_DIV-1): pulse word_done and go to RELEASE.
  - RELEASE: tx_ready=0. Wait for ready_s=0, then go to IDLE. One remote_ready high level permits exactly one word.
- ser_clk=0 and ser_data=0 in every state except SHIFT.
- remote_ready dropping during SHIFT does not abort the word; the word always completes.
- FIFO writes are accepted in every state.

## Timing
- Reset (async assert): state=IDLE, FIFO pointers=0.
  - Outputs: count=0, full=0, overflow=0, tx_ready=0, ser_clk=0, ser_data=0, busy=0, word_done=0.
  - Sync flops=0.
  - A word in flight is lost.
- count/full update on the edge following an accepted push.
- A word written into an empty FIFO while in IDLE: tx_ready rises 2 edges after the write edge.
  - Edge 1: count=1.
  - Edge 2: state=REQ.
- remote_ready first sampled high at edge E (with state=REQ): SHIFT is entered and the first bit drives ser_data at edge E+2.
- Each bit is held for exactly CLK_DIV cycles: ser_clk low for the first CLK_DIV/2 cycles, high for the rest.
- One word occupies SHIFT for DATA_WIDTH·CLK_DIV cycles. word_done is asserted in the last of these cycles.
- tx_ready falls on the edge leaving SHIFT.
- Minimum spacing between words: RELEASE→IDLE→REQ plus the synchroniser delays on remote_ready falling and rising again.

## Test plan
- Defaults, write 4'hA, hold remote_ready=1 → tx_ready rises; ser_data = 1,0,1,0, each held 4 cycles; ser_clk = 0,0,1,1 per bit; word_done after 16 SHIFT cycles; count returns to 0.
- MSB_FIRST=0, DATA_WIDTH=8, write 8'h81 then 8'h3C, toggle remote_ready once per word → bit streams 1000_0001 and 0011_1100 (LSB first); second word does not start until remote_ready has been low and then high again.
- Fill the FIFO with 4 writes while remote_ready=0, then a 5th write of 4'h7 → full=1, count=4, overflow pulses once, 4'h7 never transmitted.
- FIFO full with remote_ready held high; on the pop cycle assert wr_en with 4'hF → write rejected, overflow=1, count=3 after the edge.
- Assert rst mid-SHIFT at bit 2 → all outputs 0 immediately; after release, no residual bits appear and count=0.
- remote_ready deasserted mid-word → word completes all DATA_WIDTH bits, then RELEASE exits to IDLE two cycles later.

Source files
------------

// File: rtl/serial_link_tx.sv
// Buffered bit-serial transmitter: FIFO-queued words are shifted out on a
// ser_clk/ser_data pair under a tx_ready / remote_ready handshake.
module serial_link_tx #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int CLK_DIV    = 4,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         remote_ready,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         tx_ready,
   output logic                         ser_clk,
   output logic                         ser_data,
   output logic                         busy,
   output logic                         word_done
);

   localparam int CW   = $clog2(DEPTH+1);
   localparam int PW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int DIVW = $clog2(CLK_DIV);
   localparam int BITW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV-1);
   localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV/2);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_WIDTH-1);
   localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH-1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SHIFT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1'b1) : (w >> 1'b1);
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? PW'(0) : p + PW'(1);
   endfunction

   state_t                  state_r;
   logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [CW-1:0]           count_r;
   logic [CW-1:0]           count_nx_s;
   logic                    full_r;
   logic                    overflow_r;
   logic [1:0]              sync_r;
   logic                    ready_s;
   logic                    push_s;
   logic                    pop_s;
   logic [DATA_WIDTH-1:0]   shift_r;
   logic [DIVW-1:0]         div_cnt_r;
   logic [DIVW-1:0]         div_inc_s;
   logic [BITW-1:0]         bit_cnt_r;
   logic                    tx_ready_r;
   logic                    ser_clk_r;
   logic                    ser_data_r;
   logic                    busy_r;
   logic                    word_done_r;

   assign ready_s   = sync_r[1];
   assign push_s    = wr_en && !full_r;
   assign pop_s     = (state_r == REQ) && ready_s;
   assign div_inc_s = div_cnt_r + DIVW'(1);

   // Two-flop synchroniser for the asynchronous remote_ready input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], remote_ready};
      end
   end

   // Next buffered-word count from this cycle's push/pop pair
   always_comb begin
      count_nx_s = count_r;
      if (push_s && !pop_s) begin
         count_nx_s = count_r + CW'(1);
      end else if (!push_s && pop_s) begin
         count_nx_s = count_r - CW'(1);
      end else begin
         count_nx_s = count_r;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= PW'(0);
         rd_ptr_r   <= PW'(0);
         count_r    <= CW'(0);
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
         if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
         count_r    <= count_nx_s;
         full_r     <= (count_nx_s == CNT_FULL);
         // full_r, not the post-pop count, decides: a write while full is lost
         overflow_r <= wr_en && full_r;
      end
   end

   // Transfer FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         shift_r     <= DATA_WIDTH'(0);
         div_cnt_r   <= DIVW'(0);
         bit_cnt_r   <= BITW'(0);
         tx_ready_r  <= 1'b0;
         ser_clk_r   <= 1'b0;
         ser_data_r  <= 1'b0;
         busy_r      <= 1'b0;
         word_done_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (count_r != CW'(0)) begin
                  state_r    <= REQ;
                  tx_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end
            REQ: begin
               if (ready_s) begin
                  state_r    <= SHIFT;
                  shift_r    <= mem_r[rd_ptr_r];
                  div_cnt_r  <= DIVW'(0);
                  bit_cnt_r  <= BITW'(0);
                  ser_data_r <= head_bit(mem_r[rd_ptr_r]);
                  ser_clk_r  <= 1'b0;
               end
            end
            SHIFT: begin
               if (div_cnt_r == DIV_LAST) begin
                  div_cnt_r <= DIVW'(0);
                  ser_clk_r <= 1'b0;
                  if (bit_cnt_r == BIT_LAST) begin
                     state_r     <= RELEASE;
                     tx_ready_r  <= 1'b0;
                     ser_data_r  <= 1'b0;
                     word_done_r <= 1'b0;
                  end else begin
                     bit_cnt_r  <= bit_cnt_r + BITW'(1);
                     shift_r    <= shift_once(shift_r);
                     ser_data_r <= head_bit(shift_once(shift_r));
                  end
               end else begin
                  div_cnt_r   <= div_inc_s;
                  ser_clk_r   <= (div_inc_s >= DIV_HALF);
                  word_done_r <= (div_inc_s == DIV_LAST) && (bit_cnt_r == BIT_LAST);
               end
            end
            RELEASE: begin
               // Remote must drop ready before another word is offered
               if (!ready_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               tx_ready_r  <= 1'b0;
               ser_clk_r   <= 1'b0;
               ser_data_r  <= 1'b0;
               busy_r      <= 1'b0;
               word_done_r <= 1'b0;
            end
         endcase
      end
   end

   assign full      = full_r;
   assign count     = count_r;
   assign overflow  = overflow_r;
   assign tx_ready  = tx_ready_r;
   assign ser_clk   = ser_clk_r;
   assign ser_data  = ser_data_r;
   assign busy      = busy_r;
   assign word_done = word_done_r;

endmodule
